// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg : opcode constants and sequencer state shared by the ALU and its
//           issue sequencer.            rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

  localparam int OPC_W = 3;

  localparam logic [OPC_W-1:0] OPC_ADD  = 3'd0;
  localparam logic [OPC_W-1:0] OPC_LESS = 3'd1;
  localparam logic [OPC_W-1:0] OPC_EQ   = 3'd2;
  localparam logic [OPC_W-1:0] OPC_OR   = 3'd3;
  localparam logic [OPC_W-1:0] OPC_AND  = 3'd4;
  localparam logic [OPC_W-1:0] OPC_NOT  = 3'd5;

  localparam logic [OPC_W-1:0] OPC_LAST_LEGAL = OPC_NOT;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } seq_state_e;

  function automatic logic opc_legal(input logic [OPC_W-1:0] opc);
    return opc <= OPC_LAST_LEGAL;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_regfile.sv
// ---------------------------------------------------------------------------
// alu_regfile : REGS x N register file, two async read ports, one sync write
//               port, r0 hardwired to zero.   rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_regfile #(
  parameter int N    = 32,
  parameter int REGS = 8,
  parameter int RA_W = $clog2(REGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [RA_W-1:0] ra_addr,
  output logic [N-1:0]    ra_data,
  input  logic [RA_W-1:0] rb_addr,
  output logic [N-1:0]    rb_data,
  input  logic            we,
  input  logic [RA_W-1:0] wa,
  input  logic [N-1:0]    wd
);

  logic [N-1:0] mem [REGS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < REGS; i++) mem[i] <= '0;
    end else if (we && (wa != '0)) begin
      mem[wa] <= wd;
    end
  end

  assign ra_data = (ra_addr == '0) ? '0 : mem[ra_addr];
  assign rb_data = (rb_addr == '0) ? '0 : mem[rb_addr];

endmodule

`default_nettype wire

// File: rtl/alu_issue_seq.sv
// ---------------------------------------------------------------------------
// alu_issue_seq : single-issue sequencer in front of the combinational ALU;
//                 reads operands, registers them, writes back the result.
//                 rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_issue_seq
  import alu_pkg::*;
#(
  parameter  int N    = 32,
  parameter  int REGS = 8,
  localparam int RA_W = $clog2(REGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPC_W-1:0] in_opcode,
  input  logic [RA_W-1:0]  in_rd,
  input  logic [RA_W-1:0]  in_rs1,
  input  logic [RA_W-1:0]  in_rs2,
  input  logic             in_use_imm,
  input  logic [N-1:0]     in_imm,
  output logic [OPC_W-1:0] alu_opcode,
  output logic [N-1:0]     alu_op_a,
  output logic [N-1:0]     alu_op_b,
  input  logic [N-1:0]     alu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RA_W-1:0]  out_rd,
  output logic [N-1:0]     out_result,
  output logic             out_illegal,
  output logic [15:0]      instr_count
);

  seq_state_e   state, state_next;
  logic         accept;
  logic         wb_en;
  logic         exec_legal;
  logic [N-1:0] rs1_data, rs2_data;

  alu_regfile #(
    .N    (N),
    .REGS (REGS),
    .RA_W (RA_W)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .ra_addr (in_rs1),
    .ra_data (rs1_data),
    .rb_addr (in_rs2),
    .rb_data (rs2_data),
    .we      (wb_en),
    .wa      (out_rd),
    .wd      (alu_result)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // in_ready is deliberately independent of in_valid
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = ST_EXEC;
      end
      ST_EXEC: begin
        state_next = ST_RESP;
      end
      ST_RESP: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_next = in_valid ? ST_EXEC : ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign accept     = in_valid && in_ready;
  assign exec_legal = opc_legal(alu_opcode);
  assign wb_en      = (state == ST_EXEC) && exec_legal;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_opcode  <= '0;
      alu_op_a    <= '0;
      alu_op_b    <= '0;
      out_rd      <= '0;
      out_result  <= '0;
      out_illegal <= 1'b0;
      instr_count <= '0;
    end else begin
      if (accept) begin
        alu_opcode <= in_opcode;
        alu_op_a   <= rs1_data;
        alu_op_b   <= in_use_imm ? in_imm : rs2_data;
        out_rd     <= in_rd;
      end
      if (state == ST_EXEC) begin
        out_result  <= exec_legal ? alu_result : '0;
        out_illegal <= !exec_legal;
      end
      if (out_valid && out_ready) instr_count <= instr_count + 16'd1;
    end
  end

endmodule

`default_nettype wire
